video_page_engine: RTL and testbench
====================================

Name: video_page_engine

Overview:
- Executes bulk framebuffer operations for the VM CPU's fillVideoPage and copyVideoPage instructions: fill a whole page with one colour, or copy one page to another with a vertical scroll offset.
- Sits directly downstream of the CPU. It takes one command at a time over a valid/ready handshake and drives the page RAM write port plus one read port.
- The page RAM holds 4 pages of 320x200 4-bit pixels and is shared with the scanout/palette stage.

Parameters:
- WIDTH, 320, pixels per row
- HEIGHT, 200, rows per page
- ADDR_W, 18, page RAM address width; address = page*WIDTH*HEIGHT + y*WIDTH + x

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, can accept a command
- cmd_op  in  2  0=FILL, 1=COPY, 2/3 reserved
- cmd_dst  in  2  destination page
- cmd_src  in  2  source page (COPY only)
- cmd_color  in  4  fill colour (FILL only)
- cmd_vscroll  in  9  signed row offset, two's complement (COPY only)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when an operation completes
- mem_raddr  out  ADDR_W  page RAM read address
- mem_rdata  in  4  read data, valid exactly 1 cycle after mem_raddr
- mem_waddr  out  ADDR_W  page RAM write address
- mem_wdata  out  4  write data
- mem_we  out  1  write strobe

Behaviour:
- Reset values (clk and reset as above): IDLE state; cmd_ready=1; busy=0; done=0; mem_we=0; mem_raddr, mem_waddr and mem_wdata=0.
- Reset asserted mid-operation aborts immediately. No further writes occur and no done pulse is produced.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - All cmd_* fields are latched at accept.
  - cmd_ready = (state==IDLE).
  - busy = !cmd_ready.
- States: IDLE, FILL, COPY, DRAIN, DONE.
- IDLE:
  - Accept FILL -> FILL.
  - Accept COPY with at least one valid row -> COPY.
  - Accept COPY with no valid rows, or a reserved op -> DONE, with no memory writes.
- FILL:
  - Starting the cycle after accept, writes 64000 consecutive addresses from dst*64000 to dst*64000+63999 with mem_wdata=colour, one per cycle, with mem_we=1.
  - After the last write -> DONE.
- COPY, scroll handling:
  - Destination row y takes source row y - vscroll.
  - Valid destination rows are max(0,vs) to min(HEIGHT-1, HEIGHT-1+vs).
  - If |vs| >= HEIGHT, there are no valid rows.
  - Rows outside the valid range are not written; they keep their old contents.
- COPY, iteration order:
  - vs <= 0: valid rows are iterated ascending.
  - vs > 0: valid rows are iterated descending, so an in-place scroll (src==dst) reads each source row before it is overwritten.
  - Within a row, x always runs 0 to WIDTH-1.
- COPY, pipelining:
  - One read is issued per cycle.
  - The matching write (same x, destination row) is issued on the next cycle with mem_wdata=mem_rdata.
  - After the last read -> DRAIN. DRAIN issues the final write and goes to DONE.
- src==dst and vs==0: treated as a normal copy (64000 rewrites of identical data). No short-cut.
- DONE: done=1 for one cycle, cmd_ready=0, -> IDLE. A new command can be accepted on the following edge.
- Latency, accept at edge T:
  - FILL: mem_we high for cycles T+1 to T+64000; done at T+64001.
  - COPY with N valid rows: reads at T+1 to T+N*320; writes at T+2 to T+N*320+1; done at T+N*320+2.
- Counters:
  - x is a 9-bit counter that wraps at 319 and then steps y.
  - Row addresses use a running row-base register that adds or subtracts WIDTH per row; no multiplier in the address path.
  - The page base is a constant lookup of 0, 64000, 128000 or 192000.
- mem_raddr is don't-care when not in COPY; the RAM ignores reads.
- cmd_valid asserted while busy is ignored and does not stall the engine; the CPU holds it until ready.

Test Plan:
- Reset, then FILL dst=2 colour=0xA -> exactly 64000 writes, addresses 128000..191999, all data 0xA; done pulses once at T+64001; cmd_ready returns 1 the cycle after done.
- Preload page 0 with pattern (y*320+x)&0xF, COPY src=0 dst=1 vs=0 -> page1 == page0; 64000 writes; done at T+64002.
- COPY src=0 dst=0 vs=+10 with the same pattern -> rows 10..199 hold the original rows 0..189; rows 0..9 unchanged; writes run descending from row 199; 190*320=60800 writes.
- COPY src=3 dst=1 vs=-199 -> only dst row 0 is written, from src row 199; 320 writes; vs=-200 -> zero writes, done at T+1.
- Reserved op=3, then assert cmd_valid during an active FILL -> reserved op gives done at T+1 with no writes; the second command is not accepted until cmd_ready=1.
- Assert reset at write 1000 of a FILL -> mem_we drops asynchronously; no done pulse; after release cmd_ready=1 and a fresh FILL completes normally.

Source files
------------

// File: rtl/video_page_engine.sv
// Page fill/copy engine for 4 pages of WIDTH x HEIGHT 4-bit pixels. FILL writes from T+1 and finishes with done at T+PAGE+1. COPY reads from T+1, writes one cycle behind, and finishes with done at T+N*WIDTH+2.
// Backpressure: one command at a time; cmd_ready only in IDLE, and commands offered while busy are simply left waiting.
module video_page_engine #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_dst,
  input  logic [1:0]        cmd_src,
  input  logic [3:0]        cmd_color,
  input  logic [8:0]        cmd_vscroll,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [3:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [3:0]        mem_wdata,
  output logic              mem_we
);

  localparam int PAGE = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_COPY, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [8:0]        x_q, rows_q;
  logic              asc_q, pass_q, we_q, done_q;
  logic [ADDR_W-1:0] rd_row_q, wr_row_q, raddr_q, waddr_q;
  logic [3:0]        wdata_q;

  function automatic logic [ADDR_W-1:0] page_base(input logic [1:0] p);
    case (p)
      2'd0:    return '0;
      2'd1:    return ADDR_W'(PAGE);
      2'd2:    return ADDR_W'(2 * PAGE);
      default: return ADDR_W'(3 * PAGE);
    endcase
  endfunction

  // Constant multiply, used only to seed the row bases at accept time.
  function automatic logic [ADDR_W-1:0] row_off(input logic [8:0] r);
    return ADDR_W'(r) * ROW_STEP;
  endfunction

  logic [8:0]        abs_vs_d, nrows_d, src_row_d, dst_row_d;
  logic              asc_d, rows_ok_d, last_x, last_row;
  logic [ADDR_W-1:0] rd_start_d, wr_start_d, rd_next_d, wr_next_d;

  always_comb begin
    abs_vs_d   = cmd_vscroll[8] ? (~cmd_vscroll + 9'd1) : cmd_vscroll;
    asc_d      = cmd_vscroll[8] || (cmd_vscroll == 9'd0);
    rows_ok_d  = abs_vs_d < 9'(HEIGHT);
    nrows_d    = 9'(HEIGHT) - abs_vs_d;
    // Positive scroll walks rows bottom-up so an in-place copy never reads an overwritten row.
    src_row_d  = asc_d ? abs_vs_d : (9'(HEIGHT - 1) - cmd_vscroll);
    dst_row_d  = asc_d ? 9'd0 : 9'(HEIGHT - 1);
    rd_start_d = page_base(cmd_src) + row_off(src_row_d);
    wr_start_d = page_base(cmd_dst) + row_off(dst_row_d);
    rd_next_d  = asc_q ? (rd_row_q + ROW_STEP) : (rd_row_q - ROW_STEP);
    wr_next_d  = asc_q ? (wr_row_q + ROW_STEP) : (wr_row_q - ROW_STEP);
    last_x     = (x_q == 9'(WIDTH - 1));
    last_row   = (rows_q == 9'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      rows_q   <= '0;
      asc_q    <= 1'b0;
      pass_q   <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      rd_row_q <= '0;
      wr_row_q <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            x_q    <= '0;
            pass_q <= 1'b0;
            if (cmd_op == 2'd0) begin
              state_q <= S_FILL;
              rows_q  <= 9'(HEIGHT);
              we_q    <= 1'b1;
              waddr_q <= page_base(cmd_dst);
              wdata_q <= cmd_color;
            end else if (cmd_op == 2'd1 && rows_ok_d) begin
              state_q  <= S_COPY;
              rows_q   <= nrows_d;
              asc_q    <= asc_d;
              rd_row_q <= rd_start_d;
              wr_row_q <= wr_start_d;
              raddr_q  <= rd_start_d;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (last_x && last_row) begin
            we_q    <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            waddr_q <= waddr_q + ADDR_W'(1);
            x_q     <= last_x ? 9'd0 : x_q + 9'd1;
            if (last_x) rows_q <= rows_q - 9'd1;
          end
        end
        S_COPY: begin
          // Write lags read by one cycle; data passes straight from mem_rdata.
          we_q    <= 1'b1;
          pass_q  <= 1'b1;
          waddr_q <= wr_row_q + ADDR_W'(x_q);
          if (last_x && last_row) begin
            state_q <= S_DRAIN;
          end else if (last_x) begin
            x_q      <= '0;
            rows_q   <= rows_q - 9'd1;
            rd_row_q <= rd_next_d;
            wr_row_q <= wr_next_d;
            raddr_q  <= rd_next_d;
          end else begin
            x_q     <= x_q + 9'd1;
            raddr_q <= raddr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          we_q    <= 1'b0;
          pass_q  <= 1'b0;
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = pass_q ? mem_rdata : wdata_q;

endmodule

// File: tb/tb_video_page_engine.sv
// Directed bench for video_page_engine on a reduced 20x12 page, backed by a synchronous RAM model.
module tb_video_page_engine;
  localparam int W = 20;
  localparam int H = 12;
  localparam int PAGE = W * H;
  localparam int NW = 4 * PAGE;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0, cmd_dst = '0, cmd_src = '0;
  logic [3:0]  cmd_color = '0;
  logic [8:0]  cmd_vscroll = '0;
  logic        busy, done, mem_we;
  logic [17:0] mem_raddr, mem_waddr;
  logic [3:0]  mem_rdata = '0, mem_wdata;

  video_page_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(18)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_color(cmd_color),
    .cmd_vscroll(cmd_vscroll), .busy(busy), .done(done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat0(input int i);
    return 4'(i & 15);
  endfunction
  function automatic logic [3:0] pat3(input int i);
    return 4'((i * 7 + 3) & 15);
  endfunction

  logic [3:0] ram [0:NW-1];
  logic       load = 1'b1;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < PAGE; i++) begin
        ram[i]          <= pat0(i);
        ram[PAGE + i]   <= 4'h0;
        ram[2*PAGE + i] <= 4'h0;
        ram[3*PAGE + i] <= pat3(i);
      end
    end else if (mem_we && int'(mem_waddr) < NW) begin
      ram[int'(mem_waddr)] <= mem_wdata;
    end
    mem_rdata <= (int'(mem_raddr) < NW) ? ram[int'(mem_raddr)] : 4'h0;
  end

  int cyc = 0, acc_cyc = 0, acc_total = 0, wr_total = 0, done_total = 0, done_cyc = 0;
  int first_waddr = 0, first_wcyc = 0, last_waddr = 0, last_wcyc = 0, seq_brk = 0;
  logic first_pend = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cyc    <= cyc;
      acc_total  <= acc_total + 1;
      first_pend <= 1'b1;
    end
    if (mem_we) begin
      wr_total <= wr_total + 1;
      if (first_pend) begin
        first_waddr <= int'(mem_waddr);
        first_wcyc  <= cyc;
        first_pend  <= 1'b0;
      end else if (int'(mem_waddr) != last_waddr + 1) begin
        seq_brk <= seq_brk + 1;
      end
      last_waddr <= int'(mem_waddr);
      last_wcyc  <= cyc;
    end
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                      input logic [3:0] col, input logic [8:0] vs);
    int base;
    base = acc_total;
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_color = col; cmd_vscroll = vs;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && acc_total == base; k++) @(negedge clk);
    cmd_valid = 1'b0;
    check("accept", acc_total - base, 1);
  endtask

  // Returns the number of done pulses seen and cmd_ready while done was high.
  task automatic wait_done(input int budget, output int pulses, output int rdy_at_done);
    int base;
    base = done_total;
    rdy_at_done = -1;
    for (int k = 0; k < budget && done_total == base; k++) begin
      if (done) rdy_at_done = int'(cmd_ready);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    pulses = done_total - base;
  endtask

  initial begin
    int wb, sb, pulses, rdy, bad, ab, db;

    repeat (3) @(negedge clk);
    load = 1'b0;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_raddr", int'(mem_raddr), 0);
    check("rst_waddr", int'(mem_waddr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b1;
    @(negedge clk);

    // FILL page 2 with 0xA
    wb = wr_total; sb = seq_brk;
    send(2'd0, 2'd2, 2'd0, 4'hA, 9'd0);
    wait_done(PAGE + 20, pulses, rdy);
    check("fill_writes", wr_total - wb, PAGE);
    check("fill_first_addr", first_waddr, 2 * PAGE);
    check("fill_last_addr", last_waddr, 3 * PAGE - 1);
    check("fill_first_cyc", first_wcyc - acc_cyc, 1);
    check("fill_last_cyc", last_wcyc - acc_cyc, PAGE);
    check("fill_seq", seq_brk - sb, 0);
    check("fill_done_pulses", pulses, 1);
    check("fill_done_cyc", done_cyc - acc_cyc, PAGE + 1);
    check("fill_ready_at_done", rdy, 0);
    check("fill_ready_after", int'(cmd_ready), 1);
    bad = 0;
    for (int i = 0; i < PAGE; i++) if (ram[2*PAGE + i] !== 4'hA) bad++;
    check("fill_page2", bad, 0);

    // COPY page 0 -> page 1, no scroll
    wb = wr_total;
    send(2'd1, 2'd1, 2'd0, 4'h0, 9'd0);
    wait_done(PAGE + 20, pulses, rdy);
    check("cp0_writes", wr_total - wb, PAGE);
    check("cp0_first_addr", first_waddr, PAGE);
    check("cp0_first_cyc", first_wcyc - acc_cyc, 2);
    check("cp0_last_cyc", last_wcyc - acc_cyc, PAGE + 1);
    check("cp0_done_cyc", done_cyc - acc_cyc, PAGE + 2);
    bad = 0;
    for (int i = 0; i < PAGE; i++) if (ram[PAGE + i] !== pat0(i)) bad++;
    check("cp0_page1", bad, 0);

    // In-place COPY page 0, vs=+3: rows walk bottom-up
    wb = wr_total;
    send(2'd1, 2'd0, 2'd0, 4'h0, 9'd3);
    wait_done(PAGE + 20, pulses, rdy);
    check("cp3_writes", wr_total - wb, (H - 3) * W);
    check("cp3_first_addr", first_waddr, (H - 1) * W);
    check("cp3_last_addr", last_waddr, 3 * W + W - 1);
    check("cp3_done_cyc", done_cyc - acc_cyc, (H - 3) * W + 2);
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (ram[y*W + x] !== ((y < 3) ? pat0(y*W + x) : pat0((y - 3)*W + x))) bad++;
    check("cp3_page0", bad, 0);

    // COPY page 3 -> page 1, vs=-(H-1) (9'h1F5 = -11): only dst row 0 from src row H-1
    wb = wr_total;
    send(2'd1, 2'd1, 2'd3, 4'h0, 9'h1F5);
    wait_done(PAGE + 20, pulses, rdy);
    check("cpm_writes", wr_total - wb, W);
    check("cpm_first_addr", first_waddr, PAGE);
    check("cpm_last_addr", last_waddr, PAGE + W - 1);
    check("cpm_done_cyc", done_cyc - acc_cyc, W + 2);
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (ram[PAGE + y*W + x] !== ((y == 0) ? pat3((H - 1)*W + x) : pat0(y*W + x))) bad++;
    check("cpm_page1", bad, 0);

    // vs=-H (9'h1F4 = -12): no valid rows
    wb = wr_total;
    send(2'd1, 2'd1, 2'd3, 4'h0, 9'h1F4);
    wait_done(20, pulses, rdy);
    check("cpz_writes", wr_total - wb, 0);
    check("cpz_done_cyc", done_cyc - acc_cyc, 1);
    check("cpz_pulses", pulses, 1);

    // Reserved op
    wb = wr_total;
    send(2'd3, 2'd2, 2'd0, 4'h5, 9'd0);
    wait_done(20, pulses, rdy);
    check("rsv_writes", wr_total - wb, 0);
    check("rsv_done_cyc", done_cyc - acc_cyc, 1);

    // Command offered while a FILL runs waits for cmd_ready
    wb = wr_total;
    send(2'd0, 2'd3, 2'd0, 4'h5, 9'd0);
    repeat (3) @(negedge clk);
    check("busy_during_fill", int'(busy), 1);
    ab = acc_total;
    cmd_op = 2'd0; cmd_dst = 2'd1; cmd_color = 4'h7; cmd_valid = 1'b1;
    for (int k = 0; k < PAGE + 20 && acc_total == ab; k++) @(negedge clk);
    cmd_valid = 1'b0;
    check("held_accepts", acc_total - ab, 1);
    check("held_after_done", acc_cyc - done_cyc, 1);
    check("held_first_writes", wr_total - wb, PAGE);
    wait_done(PAGE + 20, pulses, rdy);
    check("held_second_writes", wr_total - wb, 2 * PAGE);

    // Reset in the middle of a FILL
    wb = wr_total; db = done_total;
    send(2'd0, 2'd2, 2'd0, 4'h3, 9'd0);
    for (int k = 0; k < 200 && wr_total - wb < 100; k++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_we", int'(mem_we), 0);
    repeat (3) @(negedge clk);
    check("abort_writes", wr_total - wb, 100);
    check("abort_no_done", done_total - db, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(cmd_ready), 1);
    wb = wr_total;
    send(2'd0, 2'd2, 2'd0, 4'hC, 9'd0);
    wait_done(PAGE + 20, pulses, rdy);
    check("refill_writes", wr_total - wb, PAGE);
    check("refill_done_cyc", done_cyc - acc_cyc, PAGE + 1);
    bad = 0;
    for (int i = 0; i < PAGE; i++) if (ram[2*PAGE + i] !== 4'hC) bad++;
    check("refill_page2", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
